blueintegral_mat_arb: RTL and testbench
=======================================

BLUEINTEGRAL_MAT_ARB -- requirements
Module: blueintegral_mat_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1: asynchronous active-low reset.
REQ-004 Port req_valid, input, 2: bit k high means requester k presents an operand pair.
REQ-005 Port req_ready, output, 2: bit k high means requester k's operands are accepted this cycle.
REQ-006 Port req_data0, input, 8: requester 0 operands, bits [7..4] = A00,A01,A10,A11 and bits [3..0] = B00,B01,B10,B11.
REQ-007 Port req_data1, input, 8: requester 1 operands, same packing as req_data0.
REQ-008 Port out_valid, output, 1: a result is held on out_data and out_id.
REQ-009 Port out_ready, input, 1: the consumer accepts the result.
REQ-010 Port out_data, output, 8: product C = A x B, packed [7:6]=C00, [5:4]=C01, [3:2]=C10, [1:0]=C11.
REQ-011 Port out_id, output, 1: index of the requester that owns the current result.
REQ-012 Port op_count, output, 8: count of completed result handshakes (see Configuration).

Function
REQ-013 Each Cij SHALL equal Ai0*B0j + Ai1*B1j, range 0..2, unsigned, zero-extended to 2 bits; it never overflows.
REQ-014 The FSM SHALL have three states: IDLE (no operation), CALC (operands latched), HOLD (result presented).
REQ-015 In IDLE, if any req_valid bit is high, exactly one req_ready bit SHALL be driven high (the granted requester), combinationally in the same cycle.
REQ-016 Outside IDLE, req_ready SHALL be 2'b00.
REQ-017 The round-robin arbiter SHALL grant the sole valid requester; when both are valid, it SHALL grant the requester not granted most recently.
REQ-018 The last-grant register SHALL update only on an accepted request (req_valid[k] and req_ready[k]).
REQ-019 On acceptance, the granted operands and id SHALL be latched into the operand register, and the FSM SHALL move IDLE->CALC.
REQ-020 In CALC, the product and id SHALL be registered into out_data/out_id, out_valid SHALL be set, and the FSM SHALL move CALC->HOLD; latency is 2 edges from the acceptance edge to out_valid high.
REQ-021 In HOLD, out_data, out_id and out_valid SHALL be stable until out_ready is high; on out_valid and out_ready, out_valid SHALL clear at that edge, and the FSM SHALL move HOLD->IDLE.
REQ-022 A request arriving during CALC or HOLD SHALL wait, with no acceptance; requesters SHALL hold req_valid and data until ready.
REQ-023 Peak throughput SHALL be one result per 3 cycles when out_ready is held high.
REQ-024 out_data SHALL retain its last value after the handshake; out_data is meaningful only while out_valid is high.

Reset
REQ-025 On rst_n low, the block SHALL immediately, without waiting for clk, force: state IDLE, out_valid 0, out_data 8'h00, out_id 0, op_count 8'h00, operand register 0, and the last-grant register set to requester 1 (requester 0 wins the first tie).
REQ-026 Reset asserted in CALC or HOLD SHALL discard the in-flight operation; no result for it is ever presented.
REQ-027 req_ready SHALL be 2'b00 while rst_n is low.

Configuration
REQ-028 Macro BLUEINTEGRAL_MAT_OPCOUNT_EN defined: op_count SHALL increment by 1 on each out_valid and out_ready handshake, wrapping 8'hFF->8'h00.
REQ-029 Macro BLUEINTEGRAL_MAT_OPCOUNT_EN undefined: the op_count port SHALL remain present, be tied to 8'h00, and have no counter logic synthesized.

Verification
REQ-030 Reset, then req_valid=2'b01, req_data0=8'hFF, out_ready=1 -> req_ready=2'b01 on cycle 0; out_valid high 2 edges later with out_data=8'hAA and out_id=0.
REQ-031 req_data1=8'h96 (A=identity, B=0110), requester 1 only -> out_data=8'h14, out_id=1.
REQ-032 Both requesters valid continuously, out_ready=1 -> grants alternate 0,1,0,1, with out_id matching and one result every 3 cycles.
REQ-033 out_ready=0 for 5 cycles in HOLD -> out_valid, out_data and out_id stable; req_ready=2'b00 throughout; the handshake occurs on the first cycle out_ready=1.
REQ-034 rst_n pulsed low while in HOLD -> out_valid low immediately, with no handshake; after release, the first tie is granted to requester 0.
REQ-035 With BLUEINTEGRAL_MAT_OPCOUNT_EN defined, run 257 handshakes -> op_count=8'h01; with it undefined -> op_count=8'h00 always.

Source files
------------

// File: rtl/blueintegral_mat_arb.sv
// Two-requester round-robin arbiter feeding a 2x2 boolean-operand matrix multiplier.
// Optional op_count handshake counter enabled by BLUEINTEGRAL_MAT_OPCOUNT_EN.
module blueintegral_mat_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_id,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_e;

  state_e     state_q, state_d;
  logic       lastGrant_q, lastGrant_d;
  logic [7:0] opData_q, opData_d;
  logic       opId_q, opId_d;
  logic       outValid_q, outValid_d;
  logic [7:0] outData_q, outData_d;
  logic       outId_q, outId_d;
  logic       grantId;
  logic       anyValid;
  logic       handshake;

  // Packed operands: [7:4] = A00,A01,A10,A11 and [3:0] = B00,B01,B10,B11.
  function automatic logic [7:0] matMul(input logic [7:0] ab);
    logic a00, a01, a10, a11, b00, b01, b10, b11;
    {a00, a01, a10, a11, b00, b01, b10, b11} = ab;
    return {{1'b0, a00 & b00} + {1'b0, a01 & b10},
            {1'b0, a00 & b01} + {1'b0, a01 & b11},
            {1'b0, a10 & b00} + {1'b0, a11 & b10},
            {1'b0, a10 & b01} + {1'b0, a11 & b11}};
  endfunction

  assign anyValid  = |req_valid;
  assign handshake = (state_q == HOLD) && outValid_q && out_ready;

  // On a tie the requester not granted most recently wins.
  always_comb begin
    grantId = 1'b0;
    if (req_valid == 2'b10) begin
      grantId = 1'b1;
    end else if (req_valid == 2'b11) begin
      grantId = ~lastGrant_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    opData_d    = opData_q;
    opId_d      = opId_q;
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    outId_d     = outId_q;
    req_ready   = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (anyValid && rst_n) begin
          req_ready[grantId] = 1'b1;
          lastGrant_d        = grantId;
          opData_d           = grantId ? req_data1 : req_data0;
          opId_d             = grantId;
          state_d            = CALC;
        end
      end
      CALC: begin
        outData_d  = matMul(opData_q);
        outId_d    = opId_q;
        outValid_d = 1'b1;
        state_d    = HOLD;
      end
      HOLD: begin
        if (handshake) begin
          outValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      opData_q    <= 8'h00;
      opId_q      <= 1'b0;
      outValid_q  <= 1'b0;
      outData_q   <= 8'h00;
      outId_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      opData_q    <= opData_d;
      opId_q      <= opId_d;
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      outId_q     <= outId_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_id    = outId_q;

`ifdef BLUEINTEGRAL_MAT_OPCOUNT_EN
  logic [7:0] opCount_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opCount_q <= 8'h00;
    end else if (handshake) begin
      opCount_q <= opCount_q + 8'd1;
    end
  end

  assign op_count = opCount_q;
`else
  assign op_count = 8'h00;
`endif

endmodule

// File: tb/tb_blueintegral_mat_arb.sv
// Directed self-checking bench for blueintegral_mat_arb: arbitration, product, stall,
// reset-in-flight and op_count behaviour (matches whichever macro build is compiled).
module tb_blueintegral_mat_arb;

   logic       clk;
   logic       rst_n;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [7:0] req_data0;
   logic [7:0] req_data1;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_id;
   logic [7:0] op_count;

   int errors = 0;
   int checks = 0;

   blueintegral_mat_arb dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_data0(req_data0),
      .req_data1(req_data1),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_id   (out_id),
      .op_count (op_count)
   );

   // Free-running clock; inputs change and outputs are sampled at the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reset asserted with both requesters valid: everything must read zero and nothing granted.
   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 2'b11;
      req_data0 = 8'hFF;
      req_data1 = 8'hFF;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 00", req_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", out_data); end
      checks++; if (out_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_id: got %b expected 0", out_id); end
      checks++; if (op_count !== 8'h00) begin errors++; $display("[TB] FAIL reset_opcount: got %h expected 00", op_count); end
      req_valid = 2'b00;
      rst_n     = 1'b1;
   endtask

   // Requester 0, all-ones operands: each Cij = 2 -> 8'hAA, two edges after acceptance.
   task automatic test_single_req0();
      @(negedge clk);
      req_valid = 2'b01;
      req_data0 = 8'hFF;
      out_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL r0_grant: got %b expected 01", req_ready); end
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL r0_calc_valid: got %b expected 0", out_valid); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL r0_calc_ready: got %b expected 00", req_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL r0_valid: got %b expected 1", out_valid); end
      checks++; if (out_data !== 8'hAA) begin errors++; $display("[TB] FAIL r0_data: got %h expected aa", out_data); end
      checks++; if (out_id !== 1'b0) begin errors++; $display("[TB] FAIL r0_id: got %b expected 0", out_id); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL r0_after_hs_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== 8'hAA) begin errors++; $display("[TB] FAIL r0_retain_data: got %h expected aa", out_data); end
   endtask

   // Requester 1, A = identity, B = 0110 -> C = B -> 8'h14.
   task automatic test_single_req1();
      req_valid = 2'b10;
      req_data1 = 8'h96;
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("[TB] FAIL r1_grant: got %b expected 10", req_ready); end
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL r1_valid: got %b expected 1", out_valid); end
      checks++; if (out_data !== 8'h14) begin errors++; $display("[TB] FAIL r1_data: got %h expected 14", out_data); end
      checks++; if (out_id !== 1'b1) begin errors++; $display("[TB] FAIL r1_id: got %b expected 1", out_id); end
      @(negedge clk);
   endtask

   // Both valid continuously: grants alternate 0,1,0,1 and a result completes every 3 cycles.
   task automatic test_back_to_back();
      logic [1:0] expReady;
      logic [7:0] expData;
      logic       expId;
      req_valid = 2'b11;
      req_data0 = 8'hFF;
      req_data1 = 8'h96;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expId    = (i % 2 == 1);
         expReady = expId ? 2'b10 : 2'b01;
         expData  = expId ? 8'h14 : 8'hAA;
         #1;
         checks++; if (req_ready !== expReady) begin errors++; $display("[TB] FAIL b2b_grant%0d: got %b expected %b", i, req_ready, expReady); end
         @(negedge clk);
         checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL b2b_calc_ready%0d: got %b expected 00", i, req_ready); end
         @(negedge clk);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid%0d: got %b expected 1", i, out_valid); end
         checks++; if (out_id !== expId) begin errors++; $display("[TB] FAIL b2b_id%0d: got %b expected %b", i, out_id, expId); end
         checks++; if (out_data !== expData) begin errors++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, out_data, expData); end
         @(negedge clk);
      end
      req_valid = 2'b00;
   endtask

   // Consumer stalls in HOLD while requester 1 waits; handshake on the first out_ready cycle.
   task automatic test_hold_stall();
      req_valid = 2'b01;
      req_data0 = 8'h96;
      out_ready = 1'b0;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL stall_grant: got %b expected 01", req_ready); end
      @(negedge clk);
      req_valid = 2'b10;
      req_data1 = 8'hFF;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid%0d: got %b expected 1", i, out_valid); end
         checks++; if (out_data !== 8'h14) begin errors++; $display("[TB] FAIL stall_data%0d: got %h expected 14", i, out_data); end
         checks++; if (out_id !== 1'b0) begin errors++; $display("[TB] FAIL stall_id%0d: got %b expected 0", i, out_id); end
         checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL stall_ready%0d: got %b expected 00", i, req_ready); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_hs_valid: got %b expected 0", out_valid); end
      checks++; if (req_ready !== 2'b10) begin errors++; $display("[TB] FAIL stall_waiter_grant: got %b expected 10", req_ready); end
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      checks++; if (out_data !== 8'hAA) begin errors++; $display("[TB] FAIL stall_waiter_data: got %h expected aa", out_data); end
      checks++; if (out_id !== 1'b1) begin errors++; $display("[TB] FAIL stall_waiter_id: got %b expected 1", out_id); end
      @(negedge clk);
   endtask

   // Reset pulsed in HOLD after a requester-0 grant; the first tie afterwards must go to 0.
   task automatic test_reset_in_hold();
      req_valid = 2'b01;
      req_data0 = 8'hFF;
      out_ready = 1'b0;
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rsthold_pre_valid: got %b expected 1", out_valid); end
      #2;
      req_valid = 2'b11;
      rst_n     = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rsthold_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL rsthold_data: got %h expected 00", out_data); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL rsthold_ready: got %b expected 00", req_ready); end
      checks++; if (op_count !== 8'h00) begin errors++; $display("[TB] FAIL rsthold_opcount: got %h expected 00", op_count); end
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      req_data1 = 8'h96;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL rsthold_tie: got %b expected 01", req_ready); end
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      checks++; if (out_id !== 1'b0) begin errors++; $display("[TB] FAIL rsthold_new_id: got %b expected 0", out_id); end
      checks++; if (out_data !== 8'hAA) begin errors++; $display("[TB] FAIL rsthold_new_data: got %h expected aa", out_data); end
      @(negedge clk);
   endtask

   // 257 handshakes from reset: counter wraps to 8'h01 when enabled, stays 8'h00 otherwise.
   task automatic test_opcount();
      logic [7:0] expCount;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      req_valid = 2'b01;
      req_data0 = 8'h96;
      out_ready = 1'b1;
      for (int n = 1; n <= 257; n++) begin
         repeat (3) @(negedge clk);
`ifdef BLUEINTEGRAL_MAT_OPCOUNT_EN
         expCount = 8'(n);
`else
         expCount = 8'h00;
`endif
         if (n == 1 || n == 255 || n == 256 || n == 257) begin
            checks++; if (op_count !== expCount) begin errors++; $display("[TB] FAIL opcount_%0d: got %h expected %h", n, op_count, expCount); end
         end
      end
      req_valid = 2'b00;
   endtask

   initial begin
      $display("[TB] starting blueintegral_mat_arb bench");
      test_reset();
      test_single_req0();
      test_single_req1();
      test_back_to_back();
      test_hold_stall();
      test_reset_in_hold();
      test_opcount();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
